// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and default widths for the MAC dot-product sequencer.
package mac_seq_pkg;

    localparam int A_W   = 8;
    localparam int B_W   = 8;
    localparam int SUM_W = 22;
    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, MAC datapath bus and result handshake of the sequencer.
// The slave modport is the sequencer; the master modport is its surroundings
// (operand fetch, the shared MAC and the result consumer).
interface mac_seq_ctrl_if
    import mac_seq_pkg::*;
#(
    parameter int A_width   = A_W,
    parameter int B_width   = B_W,
    parameter int SUM_width = SUM_W
);
    logic                 in_valid;
    logic [A_width-1:0]   in_a;
    logic [B_width-1:0]   in_b;
    logic                 in_ready;
    logic [A_width-1:0]   mac_a;
    logic [B_width-1:0]   mac_b;
    logic [SUM_width-1:0] mac_c;
    logic                 mac_tc;
    logic [SUM_width-1:0] mac_sum;
    logic                 res_valid;
    logic [SUM_width-1:0] res_data;
    logic                 res_ready;

    modport slave (
        input  in_valid, in_a, in_b, mac_sum, res_ready,
        output in_ready, mac_a, mac_b, mac_c, mac_tc, res_valid, res_data
    );

    modport master (
        output in_valid, in_a, in_b, mac_sum, res_ready,
        input  in_ready, mac_a, mac_b, mac_c, mac_tc, res_valid, res_data
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer driving an external combinational A*B+C unit to compute
// length-N dot products. The running sum is fed back on the C input.
// Optional macro MAC_SEQ_BIAS_EN adds a job_bias port that seeds the
// accumulator instead of zero.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int A_width   = A_W,
    parameter int B_width   = B_W,
    parameter int SUM_width = SUM_W,
    parameter int LEN_width = LEN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_width-1:0] job_len,
    input  logic                 job_tc,
    input  logic                 abort,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [SUM_width-1:0] job_bias,
`endif
    mac_seq_ctrl_if.slave        bus,
    output logic                 busy
);

    state_t               state, state_nx;
    logic [SUM_width-1:0] acc;
    logic [SUM_width-1:0] acc_init;
    logic [LEN_width-1:0] cnt;
    logic [LEN_width-1:0] len_q;
    logic                 tc_q;
    logic                 beat;
    logic                 last_beat;
    logic [A_width-1:0]   a_gated;
    logic [B_width-1:0]   b_gated;

`ifdef MAC_SEQ_BIAS_EN
    assign acc_init = job_bias;
`else
    assign acc_init = '0;
`endif

    // Beat qualification: an operand pair is consumed only while running
    always_comb begin
        beat      = (state == RUN) && bus.in_valid;
        last_beat = beat && (cnt == len_q - LEN_width'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (job_len != '0) ? RUN : DONE;
            RUN:  if (last_beat) state_nx = DONE;
            DONE: if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Accumulator, beat counter and latched job parameters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            tc_q  <= 1'b0;
        end else if (abort) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            acc   <= acc_init;
            cnt   <= '0;
            len_q <= job_len;
            tc_q  <= job_tc;
        end else if (beat) begin
            acc <= bus.mac_sum;
            cnt <= cnt + LEN_width'(1);
        end
    end

    // Datapath drive: operands gated to zero unless a beat is in progress
    always_comb begin
        a_gated = beat ? bus.in_a : '0;
        b_gated = beat ? bus.in_b : '0;
    end

    assign bus.mac_a     = a_gated;
    assign bus.mac_b     = b_gated;
    assign bus.mac_c     = acc;
    assign bus.mac_tc    = tc_q;
    assign bus.in_ready  = (state == RUN);
    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = (state == DONE) ? acc : '0;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural A*B+C unit attached.
// Optional macro MAC_SEQ_BIAS_EN must match the RTL build.
module tb_mac_seq_ctrl;
    import mac_seq_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] job_len;
    logic             job_tc;
    logic             abort;
    logic             busy;
`ifdef MAC_SEQ_BIAS_EN
    logic [SUM_W-1:0] job_bias;
    localparam logic [SUM_W-1:0] ZERO_LEN_EXP = 22'd100;
`else
    localparam logic [SUM_W-1:0] ZERO_LEN_EXP = 22'd0;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [SUM_W-1:0] exp_q[$];

    mac_seq_ctrl_if bus_if ();

    mac_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .job_len (job_len),
        .job_tc  (job_tc),
        .abort   (abort),
`ifdef MAC_SEQ_BIAS_EN
        .job_bias(job_bias),
`endif
        .bus     (bus_if.slave),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared MAC: operands extended per TC, result wraps
    logic [SUM_W-1:0] ext_a, ext_b;
    always_comb begin
        if (bus_if.mac_tc) begin
            ext_a = {{(SUM_W-A_W){bus_if.mac_a[A_W-1]}}, bus_if.mac_a};
            ext_b = {{(SUM_W-B_W){bus_if.mac_b[B_W-1]}}, bus_if.mac_b};
        end else begin
            ext_a = {{(SUM_W-A_W){1'b0}}, bus_if.mac_a};
            ext_b = {{(SUM_W-B_W){1'b0}}, bus_if.mac_b};
        end
        bus_if.mac_sum = ext_a * ext_b + bus_if.mac_c;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result handshake happens
    always @(negedge clk) begin
        if (rst_n && bus_if.res_valid && bus_if.res_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 32'(bus_if.res_valid), 32'd0);
            end else begin
                logic [SUM_W-1:0] e;
                e = exp_q.pop_front();
                checkOutput("res_data", 32'(bus_if.res_data), 32'(e));
            end
        end
    end

    // Issue a job with a one-cycle start strobe
    task automatic applyStimulus(input logic [LEN_W-1:0] len, input logic tc,
                                 input logic [SUM_W-1:0] bias);
        @(posedge clk); #1;
        start = 1'b1; job_len = len; job_tc = tc;
`ifdef MAC_SEQ_BIAS_EN
        job_bias = bias;
`else
        if (bias != '0) $display("[TB] note: bias ignored in this build");
`endif
        @(posedge clk); #1;
        start = 1'b0; job_len = 8'hFF; job_tc = ~tc;
    endtask

    task automatic sendBeat(input logic [7:0] a, input logic [7:0] b);
        bus_if.in_valid = 1'b1; bus_if.in_a = a; bus_if.in_b = b;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0;
    endtask

    task automatic drainResult();
        bus_if.res_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.res_ready = 1'b0;
        checkOutput("idle_after_handshake", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; job_len = '0; job_tc = 1'b0; abort = 1'b0;
`ifdef MAC_SEQ_BIAS_EN
        job_bias = '0;
`endif
        bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0;
        bus_if.res_ready = 1'b0;
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(bus_if.in_ready), 32'd0);
        checkOutput("reset_res_valid", 32'(bus_if.res_valid), 32'd0);
        checkOutput("reset_res_data", 32'(bus_if.res_data), 32'd0);
        #5 rst_n = 1'b1;

        // in_valid while idle is not accepted and does not reach the MAC
        @(posedge clk); #1;
        bus_if.in_valid = 1'b1; bus_if.in_a = 8'd9; bus_if.in_b = 8'd9;
        #2;
        checkOutput("idle_in_ready", 32'(bus_if.in_ready), 32'd0);
        checkOutput("idle_mac_a", 32'(bus_if.mac_a), 32'd0);
        bus_if.in_valid = 1'b0;

        // Unsigned len=3
        exp_q.push_back(22'd65067);
        applyStimulus(8'd3, 1'b0, '0);
        sendBeat(8'd3, 8'd4);
        sendBeat(8'd5, 8'd6);
        checkOutput("u3_not_yet_valid", 32'(bus_if.res_valid), 32'd0);
        sendBeat(8'd255, 8'd255);
        checkOutput("u3_res_valid", 32'(bus_if.res_valid), 32'd1);
        checkOutput("u3_cnt", 32'(dut.cnt), 32'd3);
        drainResult();

        // Signed len=2: -1*2 + -128*-128
        exp_q.push_back(22'd16382);
        applyStimulus(8'd2, 1'b1, '0);
        sendBeat(8'hFF, 8'd2);
        sendBeat(8'h80, 8'h80);
        checkOutput("s2_res_valid", 32'(bus_if.res_valid), 32'd1);
        drainResult();

        // Zero-length job
        exp_q.push_back(ZERO_LEN_EXP);
        applyStimulus(8'd0, 1'b0, 22'd100);
        checkOutput("zero_res_valid", 32'(bus_if.res_valid), 32'd1);
        checkOutput("zero_res_data", 32'(bus_if.res_data), 32'(ZERO_LEN_EXP));
        drainResult();

        // Back-pressure: gapped beats, stray start and job_len change ignored
        exp_q.push_back(22'd109);
        applyStimulus(8'd2, 1'b0, '0);
        sendBeat(8'd10, 8'd10);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1); job_len = 8'd1;
            #2;
            checkOutput("gap_mac_a", 32'(bus_if.mac_a), 32'd0);
            checkOutput("gap_acc", 32'(dut.acc), 32'd100);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checkOutput("gap_still_busy", 32'(bus_if.res_valid), 32'd0);
        sendBeat(8'd3, 8'd3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_res_valid", 32'(bus_if.res_valid), 32'd1);
            checkOutput("hold_res_data", 32'(bus_if.res_data), 32'd109);
            @(posedge clk); #1;
        end
        drainResult();

        // Abort on the final beat of len=4
        applyStimulus(8'd4, 1'b0, '0);
        sendBeat(8'd1, 8'd1);
        sendBeat(8'd2, 8'd2);
        sendBeat(8'd3, 8'd3);
        abort = 1'b1;
        sendBeat(8'd4, 8'd4);
        abort = 1'b0;
        checkOutput("abort_res_valid", 32'(bus_if.res_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        exp_q.push_back(22'd49);
        applyStimulus(8'd1, 1'b0, '0);
        sendBeat(8'd7, 8'd7);
        drainResult();

        // Asynchronous reset mid-run, then a fresh job
        applyStimulus(8'd3, 1'b0, '0);
        sendBeat(8'd5, 8'd5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        checkOutput("rst_acc", 32'(dut.acc), 32'd0);
        #3 rst_n = 1'b1;
        exp_q.push_back(22'd26);
        applyStimulus(8'd2, 1'b0, '0);
        sendBeat(8'd2, 8'd3);
        sendBeat(8'd4, 8'd5);
        drainResult();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
